// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed 7-segment driver with frame latch and blanking gap
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_driver #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_HZ  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] p0,
    input  logic [4:0] p1,
    input  logic [4:0] p2,
    input  logic [4:0] p3,
    input  logic [4:0] p4,
    input  logic [4:0] p5,
    input  logic [4:0] p6,
    input  logic [4:0] p7,
    input  logic [7:0] blink,
    output logic [7:0] tub_sel,
    output logic [7:0] seg_l,
    output logic [7:0] seg_r
);
    localparam int SLOT = CLK_HZ / SCAN_HZ;
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] BLANK_V   = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [4:0]    lat [8];
    logic [4:0]    pin [8];
    logic          end_slot;
    logic          end_frame;
    logic          hide;

    assign pin       = '{p0, p1, p2, p3, p4, p5, p6, p7};
    assign end_slot  = (cnt == SLOT_LAST);
    assign end_frame = end_slot && (idx == 3'd7);

    function automatic logic [7:0] dec(input logic [4:0] code);
        case (code)
            5'd0:    dec = 8'hFC;
            5'd1:    dec = 8'h60;
            5'd2:    dec = 8'hDA;
            5'd3:    dec = 8'hF2;
            5'd4:    dec = 8'h66;
            5'd5:    dec = 8'hB6;
            5'd6:    dec = 8'hBE;
            5'd7:    dec = 8'hE0;
            5'd8:    dec = 8'hFE;
            5'd9:    dec = 8'hF6;
            5'd10:   dec = 8'hEE;
            5'd11:   dec = 8'h3E;
            5'd12:   dec = 8'h9C;
            5'd13:   dec = 8'h7A;
            5'd14:   dec = 8'h9E;
            5'd15:   dec = 8'h8E;
            5'd16:   dec = 8'hBC;
            5'd17:   dec = 8'hFC;
            5'd18:   dec = 8'hB6;
            5'd19:   dec = 8'h1C;
            5'd20:   dec = 8'hCE;
            5'd21:   dec = 8'h7C;
            5'd22:   dec = 8'h6E;
            5'd23:   dec = 8'h02;
            default: dec = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (end_slot) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // New codes are only taken at the frame boundary so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (rst)
                lat[k] <= 5'd31;
            else if (end_frame)
                lat[k] <= pin[k];
        end
    end

`ifdef SEG_BLINK_EN
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

    logic [BW-1:0] bcnt;
    logic          phase;
    logic [7:0]    blat;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
            blat  <= 8'h00;
        end else begin
            if (bcnt == HALF_LAST) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
            if (end_frame)
                blat <= blink;
        end
    end

    assign hide = phase && blat[idx];
`else
    logic unused_blink;
    assign unused_blink = ^blink;
    assign hide         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tub_sel <= 8'h00;
            seg_l   <= 8'h00;
            seg_r   <= 8'h00;
        end else begin
            tub_sel <= 8'h00;
            seg_l   <= 8'h00;
            seg_r   <= 8'h00;
            if (cnt >= BLANK_V && !hide) begin
                tub_sel <= 8'd1 << idx;
                if (!idx[2])
                    seg_l <= dec(lat[idx]);
                else
                    seg_r <= dec(lat[idx]);
            end
        end
    end
endmodule
